// File: rtl/dma_mon_pkg.sv
// dma_mon_pkg: shared FSM state type, error bit indices and one-hot-or-zero helper for the DMA protocol monitor
package dma_mon_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, XFER = 2'd3} mon_state_t;
  localparam int ERR_ONEHOT = 0;
  localparam int ERR_STROBE = 1;
  localparam int ERR_AEN = 2;
  localparam int ERR_ADSTB = 3;
  localparam int ERR_PRIO = 4;
  localparam int ERR_TIMEOUT = 5;
  localparam int ERR_DACK_NOHOLD = 6;
  localparam logic [2:0] ERR_NONE = 3'd7;
  function automatic logic onehot0(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction
endpackage

// File: rtl/dma_mon_prio_model.sv
// dma_mon_prio_model: fixed/rotating priority reference; in i_dreq/i_dack/i_rotating/i_grant_start, out o_exp_dack (registered winner), o_win_idx (granted channel index)
module dma_mon_prio_model #(
  parameter int NUM_CH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_CH-1:0]         i_dreq,
  input  logic [NUM_CH-1:0]         i_dack,
  input  logic                      i_rotating,
  input  logic                      i_grant_start,
  output logic [NUM_CH-1:0]         o_exp_dack,
  output logic [$clog2(NUM_CH)-1:0] o_win_idx
);
  localparam int PW = $clog2(NUM_CH);
  logic [PW-1:0] r_ptr, w_pick;
  logic [NUM_CH-1:0] r_exp, w_exp;
  always_comb begin
    w_exp = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      int k;
      k = (i_rotating ? int'(r_ptr) + 1 : 0) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (w_exp == '0 && i_dreq[k]) w_exp[k] = 1'b1;
    end
  end
  always_comb begin
    w_pick = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (i_dack[i]) w_pick = PW'(i);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ptr <= PW'(NUM_CH - 1);
      r_exp <= '0;
    end else begin
      r_exp <= w_exp;
      if (i_grant_start && i_rotating) r_ptr <= w_pick;
    end
  assign o_exp_dack = r_exp;
  assign o_win_idx = w_pick;
endmodule

// File: rtl/dma_protocol_monitor.sv
// dma_protocol_monitor: passive DMA bus checker; in bus signals/rotating_pri/clr_err, out sticky err_vec, first_err, err_count, grant_count, exp_dack, mon_state
module dma_protocol_monitor
  import dma_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 8
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_CH-1:0]       DREQ,
  input  logic [NUM_CH-1:0]       DACK,
  input  logic                    HRQ,
  input  logic                    HLDA,
  input  logic                    AEN,
  input  logic                    ADSTB,
  input  logic                    IOR_N,
  input  logic                    IOW_N,
  input  logic                    MEMR_N,
  input  logic                    MEMW_N,
  input  logic                    rotating_pri,
  input  logic                    clr_err,
  output logic [6:0]              err_vec,
  output logic [2:0]              first_err,
  output logic [CNT_W-1:0]        err_count,
  output logic [NUM_CH*CNT_W-1:0] grant_count,
  output logic [NUM_CH-1:0]       exp_dack,
  output logic [1:0]              mon_state
);
  localparam int PW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT + 1);
  mon_state_t r_state, w_next;
  logic [TW-1:0] r_to_cnt;
  logic r_adstb_d, r_dack_any, w_dack_any, w_grant_start;
  logic [6:0] r_err_vec, w_err, w_err_base;
  logic [2:0] r_first_err, w_first_base, w_lsb_err;
  logic [CNT_W-1:0] r_err_count, w_cnt_base;
  logic [NUM_CH*CNT_W-1:0] r_gcnt;
  logic [NUM_CH-1:0] w_exp_dack;
  logic [PW-1:0] w_win_idx;
  assign w_dack_any = |DACK;
  assign w_grant_start = w_dack_any && !r_dack_any;
  dma_mon_prio_model #(.NUM_CH(NUM_CH)) u_prio (
    .i_clk(CLK),
    .i_rst_n(RESET_N),
    .i_dreq(DREQ),
    .i_dack(DACK),
    .i_rotating(rotating_pri),
    .i_grant_start(w_grant_start),
    .o_exp_dack(w_exp_dack),
    .o_win_idx(w_win_idx)
  );
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = !HRQ ? IDLE :
             (r_state == IDLE) ? REQ :
             (r_state == REQ && HLDA) ? HOLD :
             (r_state == HOLD && w_dack_any) ? XFER :
             (r_state == XFER && !w_dack_any) ? HOLD : r_state;
  always_comb begin
    mon_state = r_state;
    err_vec = r_err_vec;
    first_err = r_first_err;
    err_count = r_err_count;
    grant_count = r_gcnt;
    exp_dack = w_exp_dack;
  end
  // Timeout flags once, on the TIMEOUT-th cycle spent in REQ; the counter then parks at TIMEOUT
  always_comb begin
    w_err = '0;
    w_err[ERR_ONEHOT] = !onehot0(8'(DACK));
    w_err[ERR_STROBE] = (!IOR_N && !IOW_N) || (!MEMR_N && !MEMW_N);
    w_err[ERR_AEN] = w_dack_any && !AEN;
    w_err[ERR_ADSTB] = ADSTB && r_adstb_d;
    w_err[ERR_PRIO] = w_grant_start && (DACK != w_exp_dack);
    w_err[ERR_TIMEOUT] = r_state == REQ && !HLDA && r_to_cnt == TW'(TIMEOUT - 1);
    w_err[ERR_DACK_NOHOLD] = w_dack_any && (r_state == IDLE || r_state == REQ);
  end
  always_comb begin
    w_lsb_err = ERR_NONE;
    for (int i = 6; i >= 0; i--) if (w_err[i]) w_lsb_err = 3'(i);
  end
  // Clear drops the old state first; errors seen in the same cycle are then recorded on top
  assign w_err_base = clr_err ? '0 : r_err_vec;
  assign w_first_base = clr_err ? ERR_NONE : r_first_err;
  assign w_cnt_base = clr_err ? '0 : r_err_count;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      r_to_cnt <= '0;
      r_adstb_d <= 1'b0;
      r_dack_any <= 1'b0;
      r_err_vec <= '0;
      r_first_err <= ERR_NONE;
      r_err_count <= '0;
      r_gcnt <= '0;
    end else begin
      r_to_cnt <= (r_state != REQ || w_next != REQ) ? '0 :
                  (r_to_cnt == TW'(TIMEOUT)) ? r_to_cnt : r_to_cnt + TW'(1);
      r_adstb_d <= ADSTB;
      r_dack_any <= w_dack_any;
      r_err_vec <= w_err_base | w_err;
      r_first_err <= (w_first_base == ERR_NONE && |w_err) ? w_lsb_err : w_first_base;
      r_err_count <= (|w_err && w_cnt_base != '1) ? w_cnt_base + CNT_W'(1) : w_cnt_base;
      for (int i = 0; i < NUM_CH; i++)
        if (w_grant_start && w_win_idx == PW'(i) && r_gcnt[i*CNT_W +: CNT_W] != '1)
          r_gcnt[i*CNT_W +: CNT_W] <= r_gcnt[i*CNT_W +: CNT_W] + CNT_W'(1);
    end
endmodule

// File: tb/tb_dma_protocol_monitor.sv
// tb_dma_protocol_monitor: table-driven vectors plus directed rotation, timeout and async-reset sequences
module tb_dma_protocol_monitor;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  logic [3:0] DREQ, DACK;
  logic HRQ, HLDA, AEN, ADSTB, IOR_N, IOW_N, MEMR_N, MEMW_N, rotating_pri, clr_err;
  logic [6:0] err_vec;
  logic [2:0] first_err;
  logic [7:0] err_count;
  logic [31:0] grant_count;
  logic [3:0] exp_dack;
  logic [1:0] mon_state;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct packed {
    logic [3:0] dreq, dack;
    logic hrq, hlda, aen, adstb, ior_n, iow_n, memr_n, memw_n, clr;
    logic [6:0] ev;
    logic [2:0] fe;
    logic [7:0] ec;
    logic [3:0] ed;
    logic [1:0] st;
    logic [31:0] gc;
  } vec_t;
  vec_t tbl [24];
  dma_protocol_monitor #(.NUM_CH(4), .TIMEOUT(64), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK), .HRQ(HRQ), .HLDA(HLDA),
    .AEN(AEN), .ADSTB(ADSTB), .IOR_N(IOR_N), .IOW_N(IOW_N), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N),
    .rotating_pri(rotating_pri), .clr_err(clr_err), .err_vec(err_vec), .first_err(first_err),
    .err_count(err_count), .grant_count(grant_count), .exp_dack(exp_dack), .mon_state(mon_state)
  );
  always #5 CLK = ~CLK;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_bus;
    DREQ = '0; DACK = '0; HRQ = L; HLDA = L; AEN = L; ADSTB = L;
    IOR_N = H; IOW_N = H; MEMR_N = H; MEMW_N = H; rotating_pri = L; clr_err = L;
  endtask
  task automatic do_reset;
    idle_bus();
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_err_vec"}, 32'(err_vec), 32'h0);
    chk({nm, "_first_err"}, 32'(first_err), 32'd7);
    chk({nm, "_err_count"}, 32'(err_count), 32'd0);
    chk({nm, "_grant_count"}, grant_count, 32'h0);
    chk({nm, "_exp_dack"}, 32'(exp_dack), 32'h0);
    chk({nm, "_mon_state"}, 32'(mon_state), 32'd0);
  endtask
  initial begin
    tbl[0]  = '{4'h6, 4'h0, H, L, L, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h2, 2'd1, 32'h0000};
    tbl[1]  = '{4'h6, 4'h0, H, H, L, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h2, 2'd2, 32'h0000};
    tbl[2]  = '{4'h6, 4'h2, H, H, H, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h2, 2'd3, 32'h0100};
    tbl[3]  = '{4'h6, 4'h2, H, H, H, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h2, 2'd3, 32'h0100};
    tbl[4]  = '{4'h0, 4'h0, H, H, H, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h0, 2'd2, 32'h0100};
    tbl[5]  = '{4'h0, 4'h0, L, L, L, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0100};
    tbl[6]  = '{4'h0, 4'h0, H, L, L, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h0, 2'd1, 32'h0100};
    tbl[7]  = '{4'h0, 4'h0, H, H, L, L, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h0, 2'd2, 32'h0100};
    tbl[8]  = '{4'h0, 4'h3, H, H, L, L, H, H, H, H, L, 7'h15, 3'd0, 8'd1, 4'h0, 2'd3, 32'h0101};
    tbl[9]  = '{4'h0, 4'h0, L, L, L, L, H, H, H, H, H, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0101};
    tbl[10] = '{4'h0, 4'h0, L, L, L, L, L, L, H, H, L, 7'h02, 3'd1, 8'd1, 4'h0, 2'd0, 32'h0101};
    tbl[11] = '{4'h0, 4'h0, L, L, L, L, L, L, H, H, L, 7'h02, 3'd1, 8'd2, 4'h0, 2'd0, 32'h0101};
    tbl[12] = '{4'h0, 4'h0, L, L, L, L, L, L, H, H, L, 7'h02, 3'd1, 8'd3, 4'h0, 2'd0, 32'h0101};
    tbl[13] = '{4'h0, 4'h0, L, L, L, L, H, H, H, H, H, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0101};
    tbl[14] = '{4'h0, 4'h0, L, L, L, L, H, H, L, L, L, 7'h02, 3'd1, 8'd1, 4'h0, 2'd0, 32'h0101};
    tbl[15] = '{4'h0, 4'h0, L, L, L, H, H, H, H, H, L, 7'h02, 3'd1, 8'd1, 4'h0, 2'd0, 32'h0101};
    tbl[16] = '{4'h0, 4'h0, L, L, L, H, H, H, H, H, L, 7'h0A, 3'd1, 8'd2, 4'h0, 2'd0, 32'h0101};
    tbl[17] = '{4'h0, 4'h0, L, L, L, L, H, H, H, H, H, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0101};
    tbl[18] = '{4'h0, 4'h0, L, L, L, H, H, H, H, H, L, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0101};
    tbl[19] = '{4'h0, 4'h0, L, L, L, H, H, H, H, H, L, 7'h08, 3'd3, 8'd1, 4'h0, 2'd0, 32'h0101};
    tbl[20] = '{4'h0, 4'h0, L, L, L, L, L, L, H, H, H, 7'h02, 3'd1, 8'd1, 4'h0, 2'd0, 32'h0101};
    tbl[21] = '{4'h0, 4'h0, L, L, L, L, H, H, H, H, H, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0101};
    tbl[22] = '{4'h0, 4'h1, L, L, H, L, H, H, H, H, L, 7'h50, 3'd4, 8'd1, 4'h0, 2'd0, 32'h0102};
    tbl[23] = '{4'h0, 4'h0, L, L, L, L, H, H, H, H, H, 7'h00, 3'd7, 8'd0, 4'h0, 2'd0, 32'h0102};
    do_reset();
    chk_reset_vals("reset");
    for (int i = 0; i < 24; i++) begin
      DREQ = tbl[i].dreq; DACK = tbl[i].dack; HRQ = tbl[i].hrq; HLDA = tbl[i].hlda;
      AEN = tbl[i].aen; ADSTB = tbl[i].adstb; IOR_N = tbl[i].ior_n; IOW_N = tbl[i].iow_n;
      MEMR_N = tbl[i].memr_n; MEMW_N = tbl[i].memw_n; clr_err = tbl[i].clr;
      tick();
      chk($sformatf("v%0d_err_vec", i), 32'(err_vec), 32'(tbl[i].ev));
      chk($sformatf("v%0d_first_err", i), 32'(first_err), 32'(tbl[i].fe));
      chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(tbl[i].ec));
      chk($sformatf("v%0d_exp_dack", i), 32'(exp_dack), 32'(tbl[i].ed));
      chk($sformatf("v%0d_mon_state", i), 32'(mon_state), 32'(tbl[i].st));
      chk($sformatf("v%0d_grant_count", i), grant_count, tbl[i].gc);
    end
    do_reset();
    rotating_pri = H; DREQ = 4'hF; HRQ = H;
    tick();
    HLDA = H;
    tick();
    for (int g = 0; g < 4; g++) begin
      logic [3:0] one;
      one = 4'h1 << g;
      chk($sformatf("rot_exp%0d", g), 32'(exp_dack), 32'(one));
      DACK = one; AEN = H;
      tick();
      DACK = '0;
      tick();
    end
    chk("rot_no_err", 32'(err_vec), 32'h0);
    chk("rot_gcnt4", grant_count, 32'h01010101);
    chk("rot_exp_wrap", 32'(exp_dack), 32'h1);
    DACK = 4'h2;
    tick();
    chk("rot_mis_err_vec", 32'(err_vec), 32'h10);
    chk("rot_mis_first_err", 32'(first_err), 32'd4);
    chk("rot_mis_gcnt", grant_count, 32'h01010201);
    do_reset();
    HRQ = H;
    tick();
    chk("to_state_req", 32'(mon_state), 32'd1);
    repeat (63) tick();
    chk("to_not_yet", 32'(err_vec), 32'h0);
    tick();
    chk("to_err_vec", 32'(err_vec), 32'h20);
    chk("to_first_err", 32'(first_err), 32'd5);
    chk("to_state_stays", 32'(mon_state), 32'd1);
    chk("to_err_count", 32'(err_count), 32'd1);
    tick();
    chk("to_counted_once", 32'(err_count), 32'd1);
    do_reset();
    DREQ = 4'h1; HRQ = H;
    tick();
    HLDA = H; AEN = H;
    tick();
    repeat (4) begin
      DACK = 4'h1;
      tick();
      DACK = '0;
      tick();
    end
    DACK = 4'h1;
    tick();
    chk("rst_pre_gcnt", grant_count, 32'h5);
    chk("rst_pre_state", 32'(mon_state), 32'd3);
    chk("rst_pre_err", 32'(err_vec), 32'h0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    idle_bus();
    tick();
    RESET_N = 1'b1;
    tick();
    tick();
    chk("post_rst_err_vec", 32'(err_vec), 32'h0);
    chk("post_rst_err_count", 32'(err_count), 32'd0);
    chk("post_rst_first_err", 32'(first_err), 32'd7);
    chk("post_rst_state", 32'(mon_state), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
